// File: rtl/irq_capture_4bit_pkg.sv
// Shared definitions for the interrupt capture front end.
//   N_IRQ      : number of request channels
//   HOLDOFF_W  : width of the post-ack hold-off counter
//   irq_state_e: handshake FSM encoding
package irq_capture_4bit_pkg;
  localparam int N_IRQ     = 4;
  localparam int HOLDOFF_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    HOLDOFF = 2'd2
  } irq_state_e;
endpackage

// File: rtl/irq_chan_sync.sv
// One request channel: synchroniser chain plus edge/level event detect.
//   clk, rst_n : clock, synchronous active-low reset
//   req_in     : raw asynchronous request line
//   edge_mode  : 1 = rising-edge event, 0 = level event
//   evt        : event for this cycle (combinational from the flops)
module irq_chan_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_in,
  input  logic edge_mode,
  output logic evt
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // History clears with the chain, so a line already high when reset
  // drops still yields exactly one rising-edge event.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_in};
      s_d    <= s;
    end
  end

  assign evt = edge_mode ? (s & ~s_d) : s;
endmodule

// File: rtl/irq_capture_4bit.sv
// Interrupt capture ahead of the 4-bit priority encoder. Synchronises the
// raw request lines, pends events, masks them onto the encoder input and
// paces the irq/ack handshake with a hold-off counter.
//   clk, rst_n : clock, synchronous active-low reset
//   req_in     : raw request lines (async)
//   edge_mode  : per channel 1 = rising edge, 0 = level
//   mask       : per channel enable onto pend_out
//   ack        : acknowledge strobe; ack_sel = one-hot (or multi) channels
//   ovf_clr    : clear all overflow flags
//   pend_out   : pending & mask, to the encoder
//   irq        : registered interrupt request
//   ovf        : sticky per-channel overflow flags
module irq_capture_4bit
  import irq_capture_4bit_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLDOFF_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] req_in,
  input  logic [N_IRQ-1:0] edge_mode,
  input  logic [N_IRQ-1:0] mask,
  input  logic             ack,
  input  logic [N_IRQ-1:0] ack_sel,
  input  logic             ovf_clr,
  output logic [N_IRQ-1:0] pend_out,
  output logic             irq,
  output logic [N_IRQ-1:0] ovf
);
  logic [N_IRQ-1:0]     evt;
  logic [N_IRQ-1:0]     pending;
  logic [N_IRQ-1:0]     clr;
  logic [N_IRQ-1:0]     ovf_set;
  logic                 ack_acc;
  logic [HOLDOFF_W-1:0] cnt, cnt_nxt;
  irq_state_e           state, state_nxt;

  irq_chan_sync #(.SYNC_STAGES(SYNC_STAGES)) u_chan [N_IRQ-1:0] (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_in    (req_in),
    .edge_mode (edge_mode),
    .evt       (evt)
  );

  assign pend_out = pending & mask;
  assign ack_acc  = ack && (state == ACTIVE) && (ack_sel != '0);

  // A new event on a channel being cleared re-pends it and is not an
  // overflow; level channels re-pend every cycle and never overflow.
  assign ovf_set  = evt & edge_mode & pending & ~clr;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr       = '0;
    case (state)
      IDLE: begin
        if (|pend_out) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (ack_acc) begin
          clr       = ack_sel;
          cnt_nxt   = HOLDOFF_W'(HOLDOFF_CYC);
          state_nxt = HOLDOFF;
        end else if (pend_out == '0) begin
          state_nxt = IDLE;
        end
      end
      HOLDOFF: begin
        cnt_nxt = cnt - 1'b1;
        // Leaving on the count-to-zero edge gives exactly HOLDOFF_CYC
        // low cycles between the ack edge and the next irq.
        if (cnt == HOLDOFF_W'(1)) state_nxt = (|pend_out) ? ACTIVE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      pending <= '0;
      ovf     <= '0;
      irq     <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pending <= (pending & ~clr) | evt;
      ovf     <= (ovf_clr ? '0 : ovf) | ovf_set;
      irq     <= (state_nxt == ACTIVE);
    end
  end
endmodule

// File: tb/tb_irq_capture_4bit.sv
module tb_irq_capture_4bit;
  localparam int S = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, ack, ovf_clr;
  logic [3:0] req_in, edge_mode, mask, ack_sel;
  logic [3:0] pend_a, ovf_a, pend_b, ovf_b;
  logic       irq_a, irq_b;

  irq_capture_4bit #(.SYNC_STAGES(S), .HOLDOFF_CYC(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .edge_mode(edge_mode),
    .mask(mask), .ack(ack), .ack_sel(ack_sel), .ovf_clr(ovf_clr),
    .pend_out(pend_a), .irq(irq_a), .ovf(ovf_a));

  irq_capture_4bit #(.SYNC_STAGES(S), .HOLDOFF_CYC(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .edge_mode(edge_mode),
    .mask(mask), .ack(ack), .ack_sel(ack_sel), .ovf_clr(ovf_clr),
    .pend_out(pend_b), .irq(irq_b), .ovf(ovf_b));

  // Reference model: hist[k] is req_in sampled k+1 edges ago (0 across reset).
  // irq is modelled as "asserted unless inside a hold-off window, and only
  // while something unmasked is pending".
  logic [3:0] hist [S+1];
  logic [3:0] m_pend [2];
  logic [3:0] m_ovf  [2];
  bit         m_irq  [2];
  int         m_hold [2];
  int         hcyc   [2] = '{2, 5};
  int         vecs = 0, errs = 0;

  task automatic chk1(string tag, logic [31:0] got, logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    logic [3:0] evt, clr, pout;
    bit acc;
    if (!rst_n) begin
      for (int k = 0; k <= S; k++) hist[k] = '0;
      for (int d = 0; d < 2; d++) begin
        m_pend[d] = '0; m_ovf[d] = '0; m_irq[d] = 0; m_hold[d] = 0;
      end
      return;
    end
    for (int i = 0; i < 4; i++)
      evt[i] = edge_mode[i] ? (hist[S-1][i] & ~hist[S][i]) : hist[S-1][i];
    for (int k = S; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = req_in;
    for (int d = 0; d < 2; d++) begin
      pout = m_pend[d] & mask;
      acc  = ack && m_irq[d] && (ack_sel != 0);
      clr  = acc ? ack_sel : 4'b0;
      m_ovf[d]  = (ovf_clr ? 4'b0 : m_ovf[d]) | (evt & edge_mode & m_pend[d] & ~clr);
      m_pend[d] = (m_pend[d] & ~clr) | evt;
      if (acc) begin
        m_hold[d] = hcyc[d];
        m_irq[d]  = 0;
      end else if (m_hold[d] > 0) begin
        m_hold[d]--;
        m_irq[d] = (m_hold[d] == 0) && (pout != 0);
      end else begin
        m_irq[d] = (pout != 0);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk1("pend_a", pend_a, m_pend[0] & mask);
    chk1("irq_a",  irq_a,  m_irq[0]);
    chk1("ovf_a",  ovf_a,  m_ovf[0]);
    chk1("pend_b", pend_b, m_pend[1] & mask);
    chk1("irq_b",  irq_b,  m_irq[1]);
    chk1("ovf_b",  ovf_b,  m_ovf[1]);
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_ack(logic [3:0] sel);
    ack = 1'b1; ack_sel = sel; tick(); ack = 1'b0; ack_sel = '0;
  endtask

  initial begin
    int g0, g1;
    bit d0, d1;
    for (int k = 0; k <= S; k++) hist[k] = '0;
    for (int d = 0; d < 2; d++) begin
      m_pend[d] = '0; m_ovf[d] = '0; m_irq[d] = 0; m_hold[d] = 0;
    end
    rst_n = 0; req_in = 4'b1111; edge_mode = 4'b1111; mask = 4'b1111;
    ack = 0; ack_sel = 0; ovf_clr = 0;

    // Reset, then lines already high give one event each
    ticks(3);
    chk1("rst_pend", pend_a, 4'b0000);
    chk1("rst_irq",  irq_a,  1'b0);
    chk1("rst_ovf",  ovf_a,  4'b0000);
    rst_n = 1;
    ticks(2);
    chk1("lat_pend_e2", pend_a, 4'b0000);
    tick();
    chk1("lat_pend_e3", pend_a, 4'b1111);
    chk1("lat_irq_e3",  irq_a,  1'b0);
    tick();
    chk1("lat_irq_e4",  irq_a,  1'b1);
    do_ack(4'b1111);
    ticks(6);
    chk1("all_acked_irq", irq_a, 1'b0);
    req_in = 4'b0000; ticks(4);

    // Single edge channel
    req_in = 4'b0010; ticks(5);
    chk1("single_pend", pend_a, 4'b0010);
    chk1("single_irq",  irq_a,  1'b1);
    do_ack(4'b0010);
    ticks(6);
    chk1("single_idle_irq",  irq_a,  1'b0);
    chk1("single_idle_pend", pend_a, 4'b0000);
    req_in = 4'b0000; ticks(4);

    // Queueing and hold-off gap on both instances
    req_in = 4'b1010; ticks(5);
    do_ack(4'b1000);
    g0 = 0; g1 = 0; d0 = 0; d1 = 0;
    for (int i = 0; i < 12; i++) begin
      if (!d0) begin if (irq_a) d0 = 1; else g0++; end
      if (!d1) begin if (irq_b) d1 = 1; else g1++; end
      if (i < 11) tick();
    end
    chk1("gap_h2", g0, 2);
    chk1("gap_h5", g1, 5);
    chk1("queue_pend", pend_a, 4'b0010);
    do_ack(4'b0010);
    req_in = 4'b0000; ticks(6);

    // Overflow and ovf_clr collision
    for (int p = 0; p < 2; p++) begin
      req_in[0] = 1; ticks(3); req_in[0] = 0; ticks(3);
    end
    chk1("ovf_set", ovf_a, 4'b0001);
    req_in[0] = 1; ticks(2); ovf_clr = 1; tick(); ovf_clr = 0;
    chk1("ovf_collide", ovf_a, 4'b0001);
    req_in[0] = 0; ticks(3);
    ovf_clr = 1; tick(); ovf_clr = 0;
    chk1("ovf_clr", ovf_a, 4'b0000);
    do_ack(4'b0001); ticks(6);

    // Masking and level mode
    mask = 4'b0000; edge_mode = 4'b1011; req_in = 4'b0100; ticks(5);
    chk1("mask_pend", pend_a, 4'b0000);
    chk1("mask_irq",  irq_a,  1'b0);
    mask = 4'b0100; tick();
    chk1("unmask_irq", irq_a, 1'b1);
    do_ack(4'b0100); ticks(6);
    chk1("level_repend", pend_a, 4'b0100);
    chk1("level_irq",    irq_a,  1'b1);
    req_in = 4'b0000; ticks(3);
    do_ack(4'b0100); ticks(6);

    // Illegal acks, then reset from HOLDOFF
    edge_mode = 4'b1111; mask = 4'b0000; req_in = 4'b1001; ticks(4);
    do_ack(4'b0001); tick();
    mask = 4'b1111; ticks(2);
    do_ack(4'b0000); tick();
    do_ack(4'b0001);
    do_ack(4'b1000);
    chk1("holdoff_ack_ignored", pend_a, 4'b1000);
    rst_n = 0; tick(); rst_n = 1;
    chk1("rst_ho_pend", pend_a, 4'b0000);
    chk1("rst_ho_irq",  irq_a,  1'b0);
    req_in = 4'b0000; ticks(4);

    // Randomised traffic
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(3) == 0) req_in[i] = ~req_in[i];
      if ($urandom_range(15) == 0) edge_mode = 4'($urandom);
      if ($urandom_range(7) == 0)  mask = 4'($urandom);
      ack     = ($urandom_range(2) == 0);
      ack_sel = 4'($urandom);
      ovf_clr = ($urandom_range(7) == 0);
      rst_n   = ($urandom_range(80) != 0);
      tick();
    end
    rst_n = 1; ack = 0; ovf_clr = 0;
    ticks(2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/irq_capture_4bit.md
Name: irq_capture_4bit

Overview:
- Sits directly upstream of the 4-bit priority encoder.
- Synchronises four raw request lines and detects events on each line, either by edge or by level.
- Holds the events as pending bits, masks them, and drives the encoder input vector.
- Consumes the encoder's one-hot output as the acknowledge select, clears the served bit, and paces the interrupt handshake with a hold-off counter.

Parameters:
- SYNC_STAGES, 2, synchroniser depth per request line (allowed range 2..3).
- HOLDOFF_CYC, 2, number of cycles irq stays low after an accepted ack (allowed range 1..15).

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- req_in  in  4  raw request lines, asynchronous to clk.
- edge_mode  in  4  per channel: 1 = rising-edge detect, 0 = level detect.
- mask  in  4  per channel: 1 = channel enabled to pend_out.
- ack  in  1  acknowledge strobe from the consumer.
- ack_sel  in  4  one-hot channel being acknowledged (the encoder's out).
- ovf_clr  in  1  clears all ovf bits.
- pend_out  out  4  pending & mask; connects to the encoder input.
- irq  out  1  interrupt request, registered.
- ovf  out  4  sticky per-channel overflow flags.

Behaviour:
- Reset (rst_n=0 at a clk edge): all synchroniser flops, the edge-history flop, pending, ovf, the hold-off counter and irq go to 0; the FSM goes to IDLE.
  - The edge history restarts at 0, so a line already high after reset produces one rising-edge event.
- Synchroniser: SYNC_STAGES flops per bit; s = last stage; s_d = s delayed one cycle.
- Event per channel i:
  - edge_mode[i]=1: event = s & ~s_d.
  - edge_mode[i]=0: event = s.
- Pending:
  - pending[i] is set on event[i].
  - pending[i] is cleared when an ack is accepted and ack_sel[i]=1.
  - If event and clear occur in the same cycle, set wins.
- Overflow: ovf[i] sets when event[i]=1, pending[i] is already 1, and channel i is not being cleared that cycle. Level-mode channels never set ovf.
  - ovf_clr clears all ovf bits; if ovf_clr and a new overflow occur together, the overflow wins.
- pend_out = pending & mask, combinational from the pending register. Mask does not gate capture: masked channels still pend and can overflow.
- Latency (SYNC_STAGES=2), counting edges from the first edge at which req_in is stable high:
  - edge 3: pending bit set.
  - edge 4: irq high (from IDLE).
- FSM:
  - IDLE, irq=0: if |pend_out, go to ACTIVE.
  - ACTIVE, irq=1:
    - On an accepted ack: clear the ack_sel bits in pending, load the counter with HOLDOFF_CYC, go to HOLDOFF.
    - Otherwise, if pend_out==0 (masked off): go to IDLE.
  - HOLDOFF, irq=0: decrement the counter each cycle. When it reaches 0, go to ACTIVE if |pend_out, else IDLE.
  - irq is low for exactly HOLDOFF_CYC cycles between an accepted ack and the next assertion.
- Ack acceptance: ack=1, state=ACTIVE, and ack_sel!=0.
  - Ack in IDLE or HOLDOFF, or with ack_sel=0, is ignored: no clear, no state change.
  - ack_sel with several bits set clears every indicated bit; no one-hot check.
  - ack_sel bits pointing at non-pending channels are no-ops on those bits.
- Mask or edge_mode changes take effect on the next pend_out/event evaluation; no restart is required.
- irq is a registered output and is glitch-free.

Decomposition:
- Shared package: the FSM state encoding (IDLE=2'd0, ACTIVE=2'd1, HOLDOFF=2'd2), the channel count constant N_IRQ=4, and the counter width constant HOLDOFF_W=4.
- One natural sub-module: irq_chan_sync. It holds one channel's synchroniser chain and edge/level event detect, and is instantiated 4 times.
- Pending, overflow, FSM and counter stay in the top.

Test Plan:
- Reset: hold rst_n=0 with req_in=4'b1111 -> pend_out=0, irq=0, ovf=0. Release with edge_mode=4'b1111, mask=4'b1111 -> pending=4'b1111 at edge 3, irq=1 at edge 4.
- Edge channel, single event: req_in[1] rises -> pend_out=4'b0010, irq=1. Pulse ack with ack_sel=4'b0010 -> pend_out=0, irq=0 for 2 cycles, then the FSM stays in IDLE.
- Queueing and pacing: pending=4'b1010; ack with ack_sel=4'b1000 -> pend_out=4'b0010, irq low for exactly 2 cycles then high again. Repeat with HOLDOFF_CYC=5 -> gap of exactly 5 cycles.
- Overflow: edge channel 0 pulses twice with no ack -> ovf=4'b0001. Assert ovf_clr while a third pulse overflows in the same cycle -> ovf stays 4'b0001. A later ovf_clr alone -> ovf=0.
- Masking and level mode: edge_mode[2]=0, req_in[2] held high, mask=4'b0000 -> pend_out=0, irq=0, pending[2]=1. Set mask=4'b0100 -> irq=1 next cycle. Ack channel 2 while the line is still high -> pending re-sets and irq returns after the hold-off.
- Illegal acks: ack in IDLE, ack with ack_sel=0, and ack during HOLDOFF -> no change to pending or FSM. Synchronous reset in HOLDOFF -> IDLE and all outputs 0 on the next cycle.
